// File: rtl/proc_pkg.sv
// proc_pkg: shared types and field-offset helpers for param_processor.
//   opcode_t - 4-bit opcode encoding
//   state_t  - core FSM states (FETCH, EXEC, HALT)
//   op_lsb / rd_lsb - bit offsets of the op and rd fields in an instruction
//   word laid out as {op, rd, opnd}, with opnd occupying the low DATA_W bits.
package proc_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_MOV  = 4'h2,
    OP_ADD  = 4'h3,
    OP_SUB  = 4'h4,
    OP_AND  = 4'h5,
    OP_OR   = 4'h6,
    OP_XOR  = 4'h7,
    OP_IN   = 4'h8,
    OP_OUT  = 4'h9,
    OP_JMP  = 4'hA,
    OP_JZ   = 4'hB,
    OP_JC   = 4'hC,
    OP_CALL = 4'hD,
    OP_RET  = 4'hE,
    OP_HALT = 4'hF
  } opcode_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam int OP_W = 4;

  function automatic int rd_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int op_lsb(input int data_w, input int reg_aw);
    return data_w + reg_aw;
  endfunction

endpackage

// File: rtl/proc_regfile.sv
// proc_regfile: general-purpose register file for param_processor.
//   clk, rst   - clock and asynchronous active-low clear (all registers to 0)
//   we, waddr, wdata - synchronous write port
//   rd_addr/rd_data, rs_addr/rs_data - two combinational read ports
module proc_regfile #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 4,
  parameter int REG_AW   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic [REG_AW-1:0] rs_addr,
  output logic [DATA_W-1:0] rs_data
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rd_data = regs[rd_addr];
  assign rs_data = regs[rs_addr];

endmodule

// File: rtl/param_processor.sv
// param_processor: multi-cycle register-file processor, two cycles per
// instruction (FETCH then EXEC), program held in an external synchronous ROM.
//   clk        - rising-edge clock
//   rst        - asynchronous active-low reset
//   data_in    - operand sampled by IN
//   data_out   - output register written by OUT
//   out_valid  - one-cycle pulse following an OUT
//   instr_addr - program memory address, always equal to pc
//   instr_data - instruction word, valid one cycle after instr_addr
//   halted     - core stopped (HALT or stack fault)
//   stack_err  - sticky return-stack over/underflow
// Optional build macro PROC_STACK_EN adds the CALL/RET return stack;
// without it CALL/RET behave as NOP and stack_err is tied low.
module param_processor
  import proc_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int NUM_REGS    = 4,
  parameter int PROG_DEPTH  = 256,
  parameter int STACK_DEPTH = 4,
  localparam int REG_AW     = $clog2(NUM_REGS),
  localparam int PC_W       = $clog2(PROG_DEPTH),
  localparam int INSTR_W    = OP_W + REG_AW + DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  data_in,
  output logic [DATA_W-1:0]  data_out,
  output logic               out_valid,
  output logic [PC_W-1:0]    instr_addr,
  input  logic [INSTR_W-1:0] instr_data,
  output logic               halted,
  output logic               stack_err
);

  localparam int RD_LSB = rd_lsb(DATA_W);
  localparam int OP_LSB = op_lsb(DATA_W, REG_AW);

  state_t            state;
  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   pc_inc;
  logic [PC_W-1:0]   jmp_target;
  logic              z_flag;
  logic              c_flag;

  opcode_t           op;
  logic [REG_AW-1:0] rd;
  logic [REG_AW-1:0] rs;
  logic [DATA_W-1:0] opnd;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] rs_data;

  logic [DATA_W:0]   alu_wide;
  logic              flag_upd;
  logic              rf_we;
  logic [DATA_W-1:0] rf_wdata;

  assign op         = opcode_t'(instr_data[OP_LSB +: OP_W]);
  assign rd         = instr_data[RD_LSB +: REG_AW];
  assign opnd       = instr_data[DATA_W-1:0];
  assign rs         = opnd[REG_AW-1:0];
  assign instr_addr = pc;

  // Explicit wrap so non-power-of-two program depths also return to 0.
  assign pc_inc     = (pc == PC_W'(PROG_DEPTH - 1)) ? '0 : pc + 1'b1;
  // Truncating cast drops any operand bits above the pc width.
  assign jmp_target = PC_W'(opnd);

  proc_regfile #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .REG_AW   (REG_AW)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (rf_we),
    .waddr   (rd),
    .wdata   (rf_wdata),
    .rd_addr (rd),
    .rd_data (rd_data),
    .rs_addr (rs),
    .rs_data (rs_data)
  );

  // Decode / ALU: the extra top bit of alu_wide carries ADD carry-out and
  // SUB borrow (set exactly when rd < rs).
  always_comb begin
    alu_wide = '0;
    flag_upd = 1'b0;
    rf_we    = 1'b0;
    rf_wdata = '0;
    case (op)
      OP_LDI: begin rf_we = 1'b1; rf_wdata = opnd;    end
      OP_MOV: begin rf_we = 1'b1; rf_wdata = rs_data; end
      OP_IN:  begin rf_we = 1'b1; rf_wdata = data_in; end
      OP_ADD: begin alu_wide = {1'b0, rd_data} + {1'b0, rs_data}; flag_upd = 1'b1; end
      OP_SUB: begin alu_wide = {1'b0, rd_data} - {1'b0, rs_data}; flag_upd = 1'b1; end
      OP_AND: begin alu_wide = {1'b0, rd_data & rs_data}; flag_upd = 1'b1; end
      OP_OR:  begin alu_wide = {1'b0, rd_data | rs_data}; flag_upd = 1'b1; end
      OP_XOR: begin alu_wide = {1'b0, rd_data ^ rs_data}; flag_upd = 1'b1; end
      default: ;
    endcase
    if (flag_upd) begin
      rf_we    = 1'b1;
      rf_wdata = alu_wide[DATA_W-1:0];
    end
    rf_we = rf_we && (state == EXEC);
  end

`ifdef PROC_STACK_EN
  localparam int SP_W = $clog2(STACK_DEPTH + 1);
  localparam int SA_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [PC_W-1:0] stack [STACK_DEPTH];
  logic [SP_W-1:0] sp;
  logic            stack_full;
  logic            stack_empty;
  logic            push;
  logic            pop;

  assign stack_full  = (sp == SP_W'(STACK_DEPTH));
  assign stack_empty = (sp == '0);
  assign push        = (state == EXEC) && (op == OP_CALL) && !stack_full;
  assign pop         = (state == EXEC) && (op == OP_RET) && !stack_empty;

  // Return addresses need no reset; only the depth pointer does.
  always_ff @(posedge clk) begin
    if (push) stack[SA_W'(sp)] <= pc_inc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      sp <= '0;
    else if (push) sp <= sp + 1'b1;
    else if (pop)  sp <= sp - 1'b1;
  end
`else
  assign stack_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= FETCH;
      pc        <= '0;
      z_flag    <= 1'b0;
      c_flag    <= 1'b0;
      data_out  <= '0;
      out_valid <= 1'b0;
      halted    <= 1'b0;
`ifdef PROC_STACK_EN
      stack_err <= 1'b0;
`endif
    end else begin
      out_valid <= 1'b0;
      case (state)
        FETCH: state <= EXEC;
        EXEC: begin
          state <= FETCH;
          pc    <= pc_inc;
          if (flag_upd) begin
            z_flag <= (alu_wide[DATA_W-1:0] == '0);
            c_flag <= alu_wide[DATA_W];
          end
          case (op)
            OP_OUT: begin
              data_out  <= rd_data;
              out_valid <= 1'b1;
            end
            OP_JMP: pc <= jmp_target;
            OP_JZ:  if (z_flag) pc <= jmp_target;
            OP_JC:  if (c_flag) pc <= jmp_target;
            OP_HALT: begin
              pc     <= pc;
              halted <= 1'b1;
              state  <= HALT;
            end
`ifdef PROC_STACK_EN
            OP_CALL: begin
              if (stack_full) begin
                pc        <= pc;
                stack_err <= 1'b1;
                halted    <= 1'b1;
                state     <= HALT;
              end else begin
                pc <= jmp_target;
              end
            end
            OP_RET: begin
              if (stack_empty) begin
                pc        <= pc;
                stack_err <= 1'b1;
                halted    <= 1'b1;
                state     <= HALT;
              end else begin
                pc <= stack[SA_W'(sp - 1'b1)];
              end
            end
`endif
            default: ;
          endcase
        end
        HALT: ;
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_param_processor.sv
// tb_param_processor: directed programs for param_processor with a
// scoreboard of expected data_out values checked on every out_valid pulse,
// plus a second small-ROM instance for program-counter wrap.
module tb_param_processor;

  localparam int DATA_W      = 8;
  localparam int NUM_REGS    = 4;
  localparam int PROG_DEPTH  = 256;
  localparam int STACK_DEPTH = 2;
  localparam int PC_W        = 8;
  localparam int INSTR_W     = 14;

  localparam logic [3:0] I_NOP = 4'h0, I_LDI = 4'h1, I_MOV = 4'h2, I_ADD = 4'h3,
                         I_SUB = 4'h4, I_IN  = 4'h8, I_OUT = 4'h9, I_JMP = 4'hA,
                         I_JZ  = 4'hB, I_JC  = 4'hC, I_CALL = 4'hD, I_RET = 4'hE,
                         I_HALT = 4'hF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst = 1'b1;
  logic [DATA_W-1:0]  data_in = '0;
  logic [DATA_W-1:0]  data_out;
  logic               out_valid;
  logic [PC_W-1:0]    instr_addr;
  logic [INSTR_W-1:0] instr_data = '0;
  logic               halted;
  logic               stack_err;

  logic               rst_s = 1'b1;
  logic [DATA_W-1:0]  data_out_s;
  logic               out_valid_s;
  logic [1:0]         instr_addr_s;
  logic [INSTR_W-1:0] nop_word;
  logic               halted_s;
  logic               stack_err_s;

  assign nop_word = '0;

  logic [INSTR_W-1:0] rom [PROG_DEPTH];
  always @(posedge clk) instr_data <= rom[instr_addr];

  param_processor #(
    .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .PROG_DEPTH(PROG_DEPTH), .STACK_DEPTH(STACK_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_out(data_out), .out_valid(out_valid),
    .instr_addr(instr_addr), .instr_data(instr_data), .halted(halted), .stack_err(stack_err)
  );

  param_processor #(
    .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .PROG_DEPTH(4), .STACK_DEPTH(STACK_DEPTH)
  ) dut_small (
    .clk(clk), .rst(rst_s), .data_in(data_in), .data_out(data_out_s), .out_valid(out_valid_s),
    .instr_addr(instr_addr_s), .instr_data(nop_word), .halted(halted_s), .stack_err(stack_err_s)
  );

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [INSTR_W-1:0] enc(input logic [3:0] op, input logic [1:0] rd,
                                             input logic [7:0] opnd);
    return {op, rd, opnd};
  endfunction

  // Monitor: every out_valid pulse pops one expected value.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (out_valid) begin
      check("out_valid back-to-back", {31'b0, prev_valid}, 32'd0);
      if (exp_q.size() == 0) check("out_valid with nothing expected", {31'b0, out_valid}, 32'd0);
      else check("data_out", {24'b0, data_out}, {24'b0, exp_q.pop_front()});
    end
    prev_valid = out_valid;
  end

  task automatic clear_rom();
    for (int i = 0; i < PROG_DEPTH; i++) rom[i] = enc(I_HALT, 2'd0, 8'h00);
  endtask

  task automatic run_prog(input string name, input int halt_addr, input logic exp_err);
    int n;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    n = 0;
    while (!halted && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({name, " halted"}, {31'b0, halted}, 32'd1);
    check({name, " halt addr"}, {24'b0, instr_addr}, halt_addr);
    check({name, " stack_err"}, {31'b0, stack_err}, {31'b0, exp_err});
    repeat (4) @(negedge clk);
    check({name, " addr frozen"}, {24'b0, instr_addr}, halt_addr);
    check({name, " outputs drained"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    clear_rom();
    #2 rst = 1'b0;
    rst_s = 1'b0;
    repeat (3) @(negedge clk);
    check("reset data_out", {24'b0, data_out}, 32'd0);
    check("reset out_valid", {31'b0, out_valid}, 32'd0);
    check("reset halted", {31'b0, halted}, 32'd0);
    check("reset stack_err", {31'b0, stack_err}, 32'd0);
    check("reset instr_addr", {24'b0, instr_addr}, 32'd0);
    rst = 1'b1;
    #1 check("first fetch addr", {24'b0, instr_addr}, 32'd0);

    // ADD overflow: 0x7F+0x81 = 0x00 with carry, JC taken
    clear_rom();
    rom[0] = enc(I_LDI, 2'd0, 8'h7F);
    rom[1] = enc(I_LDI, 2'd1, 8'h81);
    rom[2] = enc(I_ADD, 2'd0, 8'h01);
    rom[3] = enc(I_JC,  2'd0, 8'h05);
    rom[5] = enc(I_OUT, 2'd0, 8'h00);
    exp_q.push_back(8'h00);
    run_prog("add_jc", 6, 1'b0);

    // same sum, Z must be set
    rom[3] = enc(I_JZ, 2'd0, 8'h05);
    exp_q.push_back(8'h00);
    run_prog("add_jz", 6, 1'b0);

    // echo
    clear_rom();
    data_in = 8'hA5;
    rom[0] = enc(I_IN,  2'd2, 8'h00);
    rom[1] = enc(I_OUT, 2'd2, 8'h00);
    exp_q.push_back(8'hA5);
    run_prog("echo", 2, 1'b0);

    // asynchronous clear between edges while halted with data_out=0xA5
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async data_out", {24'b0, data_out}, 32'd0);
    check("async halted", {31'b0, halted}, 32'd0);
    check("async instr_addr", {24'b0, instr_addr}, 32'd0);

    // abort an OUT mid-EXEC: no pulse, no data_out write
    clear_rom();
    rom[0] = enc(I_LDI, 2'd0, 8'h77);
    rom[1] = enc(I_OUT, 2'd0, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort instr_addr", {24'b0, instr_addr}, 32'd0);
    check("abort out_valid", {31'b0, out_valid}, 32'd0);
    repeat (3) @(negedge clk);
    check("abort data_out", {24'b0, data_out}, 32'd0);
    exp_q.push_back(8'h77);
    run_prog("restart", 2, 1'b0);

    // countdown loop
    clear_rom();
    rom[0] = enc(I_LDI, 2'd0, 8'h03);
    rom[1] = enc(I_LDI, 2'd1, 8'h01);
    rom[2] = enc(I_SUB, 2'd0, 8'h01);
    rom[3] = enc(I_OUT, 2'd0, 8'h00);
    rom[4] = enc(I_JZ,  2'd0, 8'h06);
    rom[5] = enc(I_JMP, 2'd0, 8'h02);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h00);
    run_prog("loop", 6, 1'b0);

    // 0x00-0x01 = 0xFF with borrow
    clear_rom();
    rom[0] = enc(I_LDI, 2'd0, 8'h00);
    rom[1] = enc(I_LDI, 2'd1, 8'h01);
    rom[2] = enc(I_SUB, 2'd0, 8'h01);
    rom[3] = enc(I_JC,  2'd0, 8'h05);
    rom[5] = enc(I_OUT, 2'd0, 8'h00);
    exp_q.push_back(8'hFF);
    run_prog("sub_borrow", 6, 1'b0);

    // LDI/MOV keep C=1, Z=0 from the SUB
    clear_rom();
    rom[0] = enc(I_LDI, 2'd0, 8'h00);
    rom[1] = enc(I_LDI, 2'd1, 8'h01);
    rom[2] = enc(I_SUB, 2'd0, 8'h01);
    rom[3] = enc(I_LDI, 2'd2, 8'h00);
    rom[4] = enc(I_MOV, 2'd3, 8'h02);
    rom[5] = enc(I_JC,  2'd0, 8'h07);
    rom[7] = enc(I_JZ,  2'd0, 8'h0A);
    rom[8] = enc(I_OUT, 2'd1, 8'h00);
    exp_q.push_back(8'h01);
    run_prog("flags_kept", 9, 1'b0);

    // rd==rs: SUB r,r -> 0, Z=1, C=0; ADD r,r doubles
    clear_rom();
    rom[0] = enc(I_LDI, 2'd0, 8'h05);
    rom[1] = enc(I_SUB, 2'd0, 8'h00);
    rom[2] = enc(I_JC,  2'd0, 8'h0A);
    rom[3] = enc(I_JZ,  2'd0, 8'h05);
    rom[5] = enc(I_OUT, 2'd0, 8'h00);
    rom[6] = enc(I_LDI, 2'd1, 8'h41);
    rom[7] = enc(I_ADD, 2'd1, 8'h01);
    rom[8] = enc(I_OUT, 2'd1, 8'h00);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h82);
    run_prog("self_ops", 9, 1'b0);

    // return stack
    clear_rom();
    rom[0] = enc(I_CALL, 2'd0, 8'h04);
    rom[1] = enc(I_OUT,  2'd0, 8'h00);
    rom[4] = enc(I_LDI,  2'd0, 8'h55);
    rom[5] = enc(I_RET,  2'd0, 8'h00);
`ifdef PROC_STACK_EN
    exp_q.push_back(8'h55);
`else
    exp_q.push_back(8'h00);
`endif
    run_prog("call_ret", 2, 1'b0);

    clear_rom();
    rom[0] = enc(I_CALL, 2'd0, 8'h00);
`ifdef PROC_STACK_EN
    run_prog("call_overflow", 0, 1'b1);
`else
    run_prog("call_as_nop", 1, 1'b0);
`endif

    clear_rom();
    rom[0] = enc(I_RET, 2'd0, 8'h00);
`ifdef PROC_STACK_EN
    run_prog("ret_underflow", 0, 1'b1);
`else
    run_prog("ret_as_nop", 1, 1'b0);
`endif

    // pc wrap on a 4-word program of NOPs
    @(negedge clk);
    rst_s = 1'b1;
    #1 check("wrap addr 0", {30'b0, instr_addr_s}, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      repeat (2) @(negedge clk);
      check($sformatf("wrap addr step %0d", i), {30'b0, instr_addr_s}, i % 4);
    end
    check("wrap halted", {31'b0, halted_s}, 32'd0);
    check("wrap out_valid", {31'b0, out_valid_s}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/param_processor.md
Name: param_processor

Overview:
- Parametrised successor of the 8-bit SimpleProcessor: a multi-cycle register-file processor.
- Configurable data width, register count and program depth.
- Fetches fixed-width instructions from external synchronous program memory.
- Exchanges data through data_in/data_out with an output strobe, flags, conditional branches and halt.
- Sits under a testbench or SoC top that owns the program ROM.

Parameters:
- DATA_W, 8, datapath, register and immediate width
- NUM_REGS, 4, register count (power of two, >=2); REG_AW = $clog2(NUM_REGS)
- PROG_DEPTH, 256, instruction words addressable; PC_W = $clog2(PROG_DEPTH)
- STACK_DEPTH, 4, return-stack entries (used only with PROC_STACK_EN)
- Derived localparam INSTR_W = 4 + REG_AW + DATA_W.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- data_in  in  DATA_W  input operand, sampled in EXEC of IN
- data_out  out  DATA_W  output register
- out_valid  out  1  one-cycle pulse when data_out is written
- instr_addr  out  PC_W  program memory address (= pc)
- instr_data  in  INSTR_W  instruction word; valid one cycle after instr_addr
- halted  out  1  core stopped
- stack_err  out  1  return-stack over/underflow (tied 0 without macro)

Behaviour:
- Instruction layout: [INSTR_W-1 -: 4] op, then rd (REG_AW bits), then opnd (DATA_W bits); rs = opnd[REG_AW-1:0].
- Reset (rst low, asynchronous):
  - pc=0, all regs=0, Z=0, C=0, data_out=0, out_valid=0, halted=0, stack_err=0, state=FETCH.
  - Reset asserted mid-instruction aborts it with no partial writeback.
- FSM: FETCH -> EXEC -> FETCH; HALT is absorbing until reset.
  - FETCH: instr_addr=pc.
  - EXEC: decode instr_data, write rd, flags, pc and data_out on the closing edge.
  - 2 cycles per instruction.
- instr_addr always equals pc.
- Opcodes:
  - 0 NOP
  - 1 LDI rd=opnd
  - 2 MOV rd=rs
  - 3 ADD rd=rd+rs; C=carry-out
  - 4 SUB rd=rd-rs; C=borrow (rd<rs)
  - 5 AND, 6 OR, 7 XOR: C=0
  - 8 IN rd=data_in
  - 9 OUT data_out=rd; out_valid=1 for exactly the following cycle
  - A JMP pc=opnd[PC_W-1:0]
  - B JZ: jump if Z
  - C JC: jump if C
  - D CALL, E RET (see Optional Feature)
  - F HALT
- Flag rules:
  - Z is updated by ops 3-7 only (Z = result==0).
  - C is updated by ops 3-7 only.
  - All other ops preserve both flags.
- Arithmetic is modulo 2^DATA_W.
- Non-jump ops set pc = pc+1 modulo PROG_DEPTH; pc wraps from PROG_DEPTH-1 to 0.
- JZ/JC not taken: pc+1.
- If opnd is wider than PC_W, upper bits are ignored.
- rd==rs is legal: ADD r,r doubles the register; SUB r,r gives 0 with Z=1, C=0.
- HALT: halted=1 from the edge closing its EXEC onward; no further fetches; instr_addr frozen at the HALT address.
- out_valid is never high for two consecutive cycles.

Optional Feature:
- Macro: PROC_STACK_EN.
- Enabled, CALL:
  - Pushes pc+1 and jumps to opnd.
  - Push when the stack holds STACK_DEPTH entries: stack_err=1, halted=1, no jump.
- Enabled, RET:
  - Pops into pc.
  - Pop when empty: stack_err=1, halted=1.
- stack_err is sticky until reset.
- Disabled: D/E execute as NOP (pc+1), no stack storage, stack_err tied 0.

Decomposition:
- Package proc_pkg holds:
  - opcode enum (4-bit, values above)
  - FSM state enum {FETCH, EXEC, HALT}
  - field-offset helper constants
- Sub-module proc_regfile(DATA_W, NUM_REGS):
  - two combinational read ports (rd, rs), one synchronous write port
  - asynchronous active-low clear
- Top holds pc, FSM, ALU, flags, output register and optional stack.

Test Plan:
- Reset: hold rst=0, then release → every output at its reset value, instr_addr=0 on the first FETCH. Assert rst=0 mid-EXEC between edges → outputs clear immediately, no writeback.
- ADD overflow: LDI r0,0x7F; LDI r1,0x81; ADD r0,r1; JC 5; HALT; OUT r0; HALT → taken branch, data_out=0x00 with a one-cycle out_valid, Z=1, C=1, then halted=1.
- Echo: data_in=0xA5; IN r2; OUT r2; HALT → data_out=0xA5, out_valid pulses once, halted=1.
- Loop: LDI r0,3; LDI r1,1; SUB r0,r1; OUT r0; JZ 6; JMP 2; HALT → out_valid pulses with data 0x02, 0x01, 0x00, then halted. SUB 0x00-0x01 in a variant gives 0xFF, C=1.
- Wrap and flags: PROG_DEPTH=4 program of four NOPs → instr_addr sequence 0,1,2,3,0. MOV/LDI leave Z/C unchanged.
- Stack (PROC_STACK_EN, STACK_DEPTH=2): self-recursive CALL at address 0 → third CALL sets stack_err=1, halted=1. CALL 4 at address 0 then RET at 4 → returns to 1. Without macro the same program steps pc 0→1 and stack_err stays 0.
